// File: rtl/regfile_arbiter_if.sv
// Bus bundle between two requesters, the arbiter and a 2-read/1-write register file.
// The slave modport is the arbiter's view; the master modport is the requester/register-file side.
interface regfile_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
);
  logic                  req0_valid;
  logic                  req0_write;
  logic                  req0_lock;
  logic [ADDR_WIDTH-1:0] req0_addr;
  logic [DATA_WIDTH-1:0] req0_wdata;
  logic                  req0_ready;
  logic                  resp0_valid;
  logic [DATA_WIDTH-1:0] resp0_data;

  logic                  req1_valid;
  logic                  req1_write;
  logic                  req1_lock;
  logic [ADDR_WIDTH-1:0] req1_addr;
  logic [DATA_WIDTH-1:0] req1_wdata;
  logic                  req1_ready;
  logic                  resp1_valid;
  logic [DATA_WIDTH-1:0] resp1_data;

  logic                  rf_rd0_enable;
  logic [ADDR_WIDTH-1:0] rf_rd0_addr;
  logic [DATA_WIDTH-1:0] rf_rd0_data;
  logic                  rf_rd1_enable;
  logic [ADDR_WIDTH-1:0] rf_rd1_addr;
  logic [DATA_WIDTH-1:0] rf_rd1_data;
  logic                  rf_wr_enable;
  logic [ADDR_WIDTH-1:0] rf_wr_addr;
  logic [DATA_WIDTH-1:0] rf_wr_data;

  modport slave (
    input  req0_valid, req0_write, req0_lock, req0_addr, req0_wdata,
    input  req1_valid, req1_write, req1_lock, req1_addr, req1_wdata,
    input  rf_rd0_data, rf_rd1_data,
    output req0_ready, resp0_valid, resp0_data,
    output req1_ready, resp1_valid, resp1_data,
    output rf_rd0_enable, rf_rd0_addr, rf_rd1_enable, rf_rd1_addr,
    output rf_wr_enable, rf_wr_addr, rf_wr_data
  );

  modport master (
    output req0_valid, req0_write, req0_lock, req0_addr, req0_wdata,
    output req1_valid, req1_write, req1_lock, req1_addr, req1_wdata,
    output rf_rd0_data, rf_rd1_data,
    input  req0_ready, resp0_valid, resp0_data,
    input  req1_ready, resp1_valid, resp1_data,
    input  rf_rd0_enable, rf_rd0_addr, rf_rd1_enable, rf_rd1_addr,
    input  rf_wr_enable, rf_wr_addr, rf_wr_data
  );
endinterface

// File: rtl/regfile_arbiter.sv
// Two-requester register-file arbiter: stall-free reads, round-robin shared write port with lock/timeout.
// Optional macro REGFILE_BYPASS_EN forwards a same-cycle write to a read of the same register.
module regfile_arbiter #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 3,
  parameter int LOCK_TIMEOUT = 8
) (
  input logic             clk,
  input logic             reset,
  regfile_arbiter_if.slave bus
);

  localparam int              CNT_W       = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(LOCK_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic                   last_grant_q, last_grant_d;
  logic [CNT_W-1:0]       idle_cnt_q, idle_cnt_d, idle_cnt_inc;
  logic                   resp0_valid_q, resp0_valid_d;
  logic                   resp1_valid_q, resp1_valid_d;
  logic [DATA_WIDTH-1:0]  resp0_hold_q, resp0_hold_d;
  logic [DATA_WIDTH-1:0]  resp1_hold_q, resp1_hold_d;

  logic                   rd0, rd1, wr0, wr1, gnt0, gnt1;
  logic                   owner_wr, owner_lock;
  logic                   wr_en;
  logic [ADDR_WIDTH-1:0]  wr_addr;
  logic [DATA_WIDTH-1:0]  wr_data;
  logic [DATA_WIDTH-1:0]  resp0_rdata, resp1_rdata;
  logic [DATA_WIDTH-1:0]  resp0_data, resp1_data;

  // In IDLE a tie goes to whoever did not win last; an owner blocks the other side entirely.
  always_comb begin
    rd0  = bus.req0_valid & ~bus.req0_write;
    rd1  = bus.req1_valid & ~bus.req1_write;
    wr0  = bus.req0_valid &  bus.req0_write;
    wr1  = bus.req1_valid &  bus.req1_write;
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    case (state_q)
      IDLE: begin
        if (wr0 && wr1) begin
          gnt0 = last_grant_q;
          gnt1 = ~last_grant_q;
        end else begin
          gnt0 = wr0;
          gnt1 = wr1;
        end
      end
      OWN0:    gnt0 = wr0;
      OWN1:    gnt1 = wr1;
      default: ;
    endcase
  end

  always_comb begin
    wr_en   = gnt0 | gnt1;
    wr_addr = '0;
    wr_data = '0;
    if (gnt0) begin
      wr_addr = bus.req0_addr;
      wr_data = bus.req0_wdata;
    end else if (gnt1) begin
      wr_addr = bus.req1_addr;
      wr_data = bus.req1_wdata;
    end
  end

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    idle_cnt_d    = idle_cnt_q;
    owner_wr      = (state_q == OWN1) ? wr1 : wr0;
    owner_lock    = (state_q == OWN1) ? bus.req1_lock : bus.req0_lock;
    idle_cnt_inc  = idle_cnt_q + 1'b1;
    resp0_valid_d = rd0;
    resp1_valid_d = rd1;
    resp0_hold_d  = resp0_data;
    resp1_hold_d  = resp1_data;

    if (gnt0) begin
      last_grant_d = 1'b0;
    end else if (gnt1) begin
      last_grant_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        idle_cnt_d = '0;
        if (gnt0 && bus.req0_lock) begin
          state_d = OWN0;
        end else if (gnt1 && bus.req1_lock) begin
          state_d = OWN1;
        end
      end
      OWN0, OWN1: begin
        // The count reaching the timeout on this edge makes the next cycle IDLE.
        if (owner_wr) begin
          idle_cnt_d = '0;
          if (!owner_lock) begin
            state_d = IDLE;
          end
        end else if (idle_cnt_inc == TIMEOUT_CNT) begin
          idle_cnt_d = '0;
          state_d    = IDLE;
        end else begin
          idle_cnt_d = idle_cnt_inc;
        end
      end
      default: begin
        state_d    = IDLE;
        idle_cnt_d = '0;
      end
    endcase
  end

`ifdef REGFILE_BYPASS_EN
  logic                  byp0_q, byp0_d;
  logic                  byp1_q, byp1_d;
  logic [DATA_WIDTH-1:0] byp_data_q, byp_data_d;

  always_comb begin
    byp0_d     = rd0 & wr_en & (wr_addr == bus.req0_addr);
    byp1_d     = rd1 & wr_en & (wr_addr == bus.req1_addr);
    byp_data_d = wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byp0_q     <= 1'b0;
      byp1_q     <= 1'b0;
      byp_data_q <= '0;
    end else begin
      byp0_q     <= byp0_d;
      byp1_q     <= byp1_d;
      byp_data_q <= byp_data_d;
    end
  end

  assign resp0_rdata = byp0_q ? byp_data_q : bus.rf_rd0_data;
  assign resp1_rdata = byp1_q ? byp_data_q : bus.rf_rd1_data;
`else
  assign resp0_rdata = bus.rf_rd0_data;
  assign resp1_rdata = bus.rf_rd1_data;
`endif

  // Register-file data arrives a cycle after the enable, so the response passes it straight through.
  assign resp0_data = resp0_valid_q ? resp0_rdata : resp0_hold_q;
  assign resp1_data = resp1_valid_q ? resp1_rdata : resp1_hold_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      last_grant_q  <= 1'b1;
      idle_cnt_q    <= '0;
      resp0_valid_q <= 1'b0;
      resp1_valid_q <= 1'b0;
      resp0_hold_q  <= '0;
      resp1_hold_q  <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      idle_cnt_q    <= idle_cnt_d;
      resp0_valid_q <= resp0_valid_d;
      resp1_valid_q <= resp1_valid_d;
      resp0_hold_q  <= resp0_hold_d;
      resp1_hold_q  <= resp1_hold_d;
    end
  end

  assign bus.req0_ready    = rd0 | gnt0;
  assign bus.req1_ready    = rd1 | gnt1;
  assign bus.rf_rd0_enable = rd0;
  assign bus.rf_rd1_enable = rd1;
  assign bus.rf_rd0_addr   = bus.req0_addr;
  assign bus.rf_rd1_addr   = bus.req1_addr;
  assign bus.rf_wr_enable  = wr_en;
  assign bus.rf_wr_addr    = wr_addr;
  assign bus.rf_wr_data    = wr_data;
  assign bus.resp0_valid   = resp0_valid_q;
  assign bus.resp1_valid   = resp1_valid_q;
  assign bus.resp0_data    = resp0_data;
  assign bus.resp1_data    = resp1_data;

endmodule

// File: doc/regfile_arbiter.md
REGFILE_ARBITER -- requirements
Module: regfile_arbiter

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- DATA_WIDTH, 8, register width.
- ADDR_WIDTH, 3, register index width (8 registers).
- LOCK_TIMEOUT, 8, idle owner cycles before forced write-port release.

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning); N = 0, 1 denotes one port per requester:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- reqN_valid  in  1  requester N transaction valid.
- reqN_write  in  1  1 = write, 0 = read.
- reqN_lock  in  1  keep write-port ownership after this write.
- reqN_addr  in  ADDR_WIDTH  register index.
- reqN_wdata  in  DATA_WIDTH  write data.
- reqN_ready  out  1  transaction accepted this cycle.
- respN_valid  out  1  read data valid.
- respN_data  out  DATA_WIDTH  read data.
- rf_rdN_enable  out  1  register-file read port N enable.
- rf_rdN_addr  out  ADDR_WIDTH  register-file read port N address.
- rf_rdN_data  in  DATA_WIDTH  register-file read port N data, valid one cycle after enable.
- rf_wr_enable  out  1  register-file write enable.
- rf_wr_addr  out  ADDR_WIDTH  register-file write address.
- rf_wr_data  out  DATA_WIDTH  register-file write data.

Function
REQ-003 Reads SHALL never stall: reqN_valid & !reqN_write -> reqN_ready=1, rf_rdN_enable=1, rf_rdN_addr=reqN_addr, same cycle (combinational).
REQ-004 For a read accepted in cycle T, respN_valid SHALL be 1 in T+1 only, with respN_data = rf_rdN_data; otherwise respN_valid=0 and respN_data holds its last value.
REQ-005 Writes SHALL share the single write port; a granted write drives rf_wr_enable=1 and rf_wr_addr/rf_wr_data from the winner in the same cycle, with reqN_ready=1; a loser sees reqN_ready=0 and holds its request.
REQ-006 FSM SHALL have states IDLE, OWN0, OWN1.
REQ-007 IDLE: a single write requester SHALL be granted; when both request, the requester other than last_grant SHALL win (round-robin); last_grant updates on every grant.
REQ-008 IDLE -> OWNN SHALL occur when requester N's write is granted with reqN_lock=1; otherwise the FSM stays in IDLE.
REQ-009 OWNN: only requester N's writes SHALL be granted; the other requester's writes stall (ready=0) even when N is silent.
REQ-010 OWNN -> IDLE SHALL occur when N's granted write has reqN_lock=0, or when the idle counter reaches LOCK_TIMEOUT.
REQ-011 In OWNN, the idle counter SHALL increment each cycle without a write from N, clear on any write from N, and clear on leaving OWNN; the release takes effect the cycle after the count equals LOCK_TIMEOUT.
REQ-012 With no granted write, rf_wr_enable SHALL be 0, and rf_wr_addr and rf_wr_data SHALL be 0.

Reset
REQ-013 reset low SHALL immediately set: state=IDLE, last_grant=1 (requester 0 wins the first tie), idle counter=0, respN_valid=0, respN_data=0.
REQ-014 A read accepted in the cycle reset asserts SHALL produce no response; a lock held at reset SHALL be released.

Configuration
REQ-015 Macro REGFILE_BYPASS_EN defined: a read accepted in the same cycle as a granted write to the same address SHALL return that cycle's rf_wr_data in respN_data at T+1. Undefined: the response SHALL be rf_rdN_data unmodified.

Verification
REQ-016 Write r3=42 by req0, then req1 reads r3 -> rf_wr_enable=1 addr 3 data 42; resp1_valid one cycle after accept; resp1_data=42 with the rf model.
REQ-017 Both write in the same cycle after reset (req0 r1=10, req1 r2=20) -> req0 granted first, req1 ready=0, then req1 granted the next cycle; the following tie goes to req0.
REQ-018 req0 write r5=7 with lock=1, then req1 write pending for 3 cycles while req0 writes r6=8 with lock=0 -> req1 stalled until the cycle after the r6 write, then granted.
REQ-019 req0 locks, then stays silent while req1 requests -> req1 granted on the cycle after 8 idle cycles (LOCK_TIMEOUT=8).
REQ-020 Same-cycle req0 write r7=99 and req1 read r7, rf holding r7=49 -> with REGFILE_BYPASS_EN resp1_data=99; without it resp1_data=49.
REQ-021 reset asserted mid-lock with a read accepted in the same cycle -> respN_valid=0 and state IDLE immediately; after release, tie goes to req0.
